pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data width in bits; power of two, >= 2.
REQ-002 SHALL have parameter NUM_STAGES, default $clog2(DATA_WIDTH), register stage count; range 1..$clog2(DATA_WIDTH).
REQ-003 SHALL have port i_clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_data  input  DATA_WIDTH  operand.
REQ-006 SHALL have port i_amt  input  $clog2(DATA_WIDTH)  shift/rotate amount.
REQ-007 SHALL have port i_dir  input  1  direction: 0 left (toward MSB), 1 right.
REQ-008 SHALL have port i_op  input  2  operation (shift_op_t): 0 rotate, 1 logical shift, 2 arithmetic shift, 3 reserved.
REQ-009 SHALL have port i_valid  input  1  input beat valid.
REQ-010 SHALL have port o_ready  output  1  block accepts beat this cycle.
REQ-011 SHALL have port o_data  output  DATA_WIDTH  result.
REQ-012 SHALL have port o_valid  output  1  result valid.
REQ-013 SHALL have port i_ready  input  1  downstream accepts result.

Function
REQ-014 SHALL transfer an input beat when i_valid && o_ready, an output beat when o_valid && i_ready.
REQ-015 SHALL decompose i_amt bits LSB-first across NUM_STAGES stages, ceil($clog2(DATA_WIDTH)/NUM_STAGES) bits per stage, last stage taking the remainder.
REQ-016 SHALL register each stage's data, remaining amount, dir, op and valid; latency exactly NUM_STAGES cycles from accept to o_valid with i_ready held high.
REQ-017 Rotate: left moves bit i to (i+amt) mod DATA_WIDTH; right moves bit i to (i-amt) mod DATA_WIDTH.
REQ-018 Logical shift: vacated positions fill with 0.
REQ-019 Arithmetic shift right: vacated MSBs fill with operand bit DATA_WIDTH-1 as sampled at accept; arithmetic left identical to logical left.
REQ-020 Reserved op 3 SHALL pass data through unmodified (amount ignored).
REQ-021 amt = 0 SHALL return i_data unchanged for every op and direction.
REQ-022 Stage k SHALL load when its register is empty or stage k+1 (or output for last stage) is loading/consuming; o_ready = stage-0 load condition.
REQ-023 Full pipeline with i_ready high SHALL sustain one beat per cycle (o_ready held 1).
REQ-024 With i_ready low, o_data/o_valid SHALL hold stable; bubbles ahead of the stall SHALL collapse; o_ready SHALL drop only when all stages valid.
REQ-025 Beats SHALL exit in acceptance order; none dropped or duplicated.
REQ-026 Stage data registers without valid MAY hold don't-care; o_data SHALL be meaningful only when o_valid=1.

Reset
REQ-027 i_reset high SHALL asynchronously clear all stage valid bits: o_valid=0, o_ready=1 within the same cycle after reset release.
REQ-028 Data/amount/op registers SHALL reset to 0; o_data=0 during reset.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no output beat for them after release.

Structure
REQ-030 Package shift_pkg SHALL hold shift_op_t enum (OP_ROTATE, OP_LSHIFT, OP_ASHIFT, OP_RESERVED) and direction constants DIR_LEFT/DIR_RIGHT.
REQ-031 One combinational sub-module barrel_stage SHALL apply a partial amount (given bit slice, weight offset) for dir/op; instantiated NUM_STAGES times via generate.
REQ-032 No latches; all registers in i_clock domain with async i_reset.

Verification (DATA_WIDTH=8, NUM_STAGES=3 unless noted)
REQ-033 Rotate left 8'b1000_0001 amt 1 -> 8'b0000_0011 after exactly 3 cycles; rotate right same -> 8'b1100_0000.
REQ-034 Arithmetic right 8'h90 amt 3 -> 8'hF2; logical right 8'h90 amt 3 -> 8'h12; logical left 8'h90 amt 3 -> 8'h80.
REQ-035 Back-to-back 8 beats, i_ready=1 -> 8 results on consecutive cycles in order, o_ready constant 1.
REQ-036 i_ready=0 for 5 cycles with continuous i_valid -> o_ready falls after 3 accepts, o_data held stable, all beats recovered in order after i_ready=1.
REQ-037 Assert i_reset with 2 beats in flight -> o_valid=0 immediately, no result for those beats after release.
REQ-038 NUM_STAGES=1 and NUM_STAGES=2 builds: exhaustive all data x amt x dir x op vs. reference model, latency 1 and 2 respectively.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: operation and direction encodings shared by the barrel shifter blocks
package shift_pkg;
    typedef enum logic [1:0] {
        OP_ROTATE   = 2'd0,
        OP_LSHIFT   = 2'd1,
        OP_ASHIFT   = 2'd2,
        OP_RESERVED = 2'd3
    } shift_op_t;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: applies the amount bits in [LO, HI) for one pipeline stage, combinationally
module barrel_stage
    import shift_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int LO = 0,
    parameter int HI = 1
) (
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] amt_i,
    input  logic          dir_i,
    input  logic [1:0]    op_i,
    output logic [DW-1:0] data_o
);
    localparam logic [AW-1:0] MASK = AW'(((1 << HI) - 1) & ~((1 << LO) - 1));
    function automatic logic [DW-1:0] shift_by(input logic [DW-1:0] d, input int w, input logic dir, input logic [1:0] op);
        logic [DW-1:0] fill;
        fill = (op == OP_ASHIFT && d[DW-1]) ? ~({DW{1'b1}} >> w) : '0;
        if (op == OP_ROTATE)
            return dir == DIR_LEFT ? (d << w) | (d >> (DW - w)) : (d >> w) | (d << (DW - w));
        return dir == DIR_LEFT ? d << w : (d >> w) | fill;
    endfunction
    always_comb begin
        data_o = op_i == OP_RESERVED ? data_i : shift_by(data_i, int'(amt_i & MASK), dir_i, op_i);
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: rotate/shift unit split across NUM_STAGES valid/ready register stages
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_STAGES = $clog2(DATA_WIDTH)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic [$clog2(DATA_WIDTH)-1:0] i_amt,
    input  logic                          i_dir,
    input  logic [1:0]                    i_op,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    input  logic                          i_ready
);
    localparam int AW  = $clog2(DATA_WIDTH);
    localparam int BPS = (AW + NUM_STAGES - 1) / NUM_STAGES;
    function automatic int hi_bit(input int j);
        return (j + 1) * BPS < AW ? (j + 1) * BPS : AW;
    endfunction
    logic [DATA_WIDTH-1:0] data_d [NUM_STAGES];
    logic [DATA_WIDTH-1:0] data_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] shifted [NUM_STAGES];
    logic [AW-1:0]         amt_d [NUM_STAGES];
    logic [AW-1:0]         amt_q [NUM_STAGES];
    logic [1:0]            op_d [NUM_STAGES];
    logic [1:0]            op_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] dir_d, dir_q, vld_d, vld_q, load;
    logic                  go;
    always_comb begin
        go = i_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            go      = go || !vld_q[k];
            load[k] = go;
        end
    end
    always_comb begin
        data_d[0] = i_data;
        amt_d[0]  = i_amt;
        dir_d[0]  = i_dir;
        op_d[0]   = i_op;
        vld_d[0]  = i_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            data_d[k] = shifted[k-1];
            amt_d[k]  = (amt_q[k-1] >> hi_bit(k - 1)) << hi_bit(k - 1);
            dir_d[k]  = dir_q[k-1];
            op_d[k]   = op_q[k-1];
            vld_d[k]  = vld_q[k-1];
        end
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                op_q[k]   <= '0;
            end
            dir_q <= '0;
            vld_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (load[k]) begin
                    data_q[k] <= data_d[k];
                    amt_q[k]  <= amt_d[k];
                    op_q[k]   <= op_d[k];
                    dir_q[k]  <= dir_d[k];
                    vld_q[k]  <= vld_d[k];
                end
            end
        end
    end
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        barrel_stage #(
            .DW(DATA_WIDTH),
            .AW(AW),
            .LO(g * BPS < AW ? g * BPS : AW),
            .HI(hi_bit(g))
        ) u_stage (
            .data_i(data_q[g]),
            .amt_i (amt_q[g]),
            .dir_i (dir_q[g]),
            .op_i  (op_q[g]),
            .data_o(shifted[g])
        );
    end
    assign o_ready = load[0];
    assign o_valid = vld_q[NUM_STAGES-1];
    assign o_data  = shifted[NUM_STAGES-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: vectors, stall/reset sequences, random scoreboard and exhaustive 1/2-stage sweeps
module tb_pipelined_barrel_shifter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [1:0] op;
    logic       vld;
    logic       rdy;
    logic       o_ready3, o_valid3, o_ready2, o_valid2, o_ready1, o_valid1;
    logic [7:0] o_data3, o_data2, o_data1;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sbq[$];
    logic [7:0] ex[16384];

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] a;
        logic       dr;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.DATA_WIDTH(8), .NUM_STAGES(3)) u3 (
        .i_clock(clk), .i_reset(rst), .i_data(data), .i_amt(amt), .i_dir(dir), .i_op(op),
        .i_valid(vld), .o_ready(o_ready3), .o_data(o_data3), .o_valid(o_valid3), .i_ready(rdy));
    pipelined_barrel_shifter #(.DATA_WIDTH(8), .NUM_STAGES(2)) u2 (
        .i_clock(clk), .i_reset(rst), .i_data(data), .i_amt(amt), .i_dir(dir), .i_op(op),
        .i_valid(vld), .o_ready(o_ready2), .o_data(o_data2), .o_valid(o_valid2), .i_ready(rdy));
    pipelined_barrel_shifter #(.DATA_WIDTH(8), .NUM_STAGES(1)) u1 (
        .i_clock(clk), .i_reset(rst), .i_data(data), .i_amt(amt), .i_dir(dir), .i_op(op),
        .i_valid(vld), .o_ready(o_ready1), .o_data(o_data1), .o_valid(o_valid1), .i_ready(rdy));

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] o);
        logic [7:0] r;
        int s;
        s = int'(a);
        r = d;
        if (o == 2'd0)
            for (int i = 0; i < 8; i++) r[dr ? (i - s + 8) % 8 : (i + s) % 8] = d[i];
        else if (o == 2'd1)
            r = dr ? d >> s : d << s;
        else if (o == 2'd2)
            r = dr ? 8'($signed(d) >>> s) : d << s;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        data = 8'($urandom);
        amt  = 3'($urandom);
        dir  = 1'($urandom);
        op   = 2'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst) sbq.delete();
        else begin
            if (o_valid3 && rdy) begin
                if (sbq.size() == 0) chk("sb_unexpected_beat", 32'(o_data3), 32'hFFFF_FFFF);
                else chk("sb_data", 32'(o_data3), 32'(sbq.pop_front()));
            end
            if (vld && o_ready3) sbq.push_back(ref_shift(data, amt, dir, op));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, vc, first, lastv, acc;
        logic [7:0] held;
        tbl[0]  = '{8'h81, 3'd1, 1'b0, 2'd0, 8'h03};
        tbl[1]  = '{8'h81, 3'd1, 1'b1, 2'd0, 8'hC0};
        tbl[2]  = '{8'h90, 3'd3, 1'b1, 2'd2, 8'hF2};
        tbl[3]  = '{8'h90, 3'd3, 1'b1, 2'd1, 8'h12};
        tbl[4]  = '{8'h90, 3'd3, 1'b0, 2'd1, 8'h80};
        tbl[5]  = '{8'hA5, 3'd5, 1'b0, 2'd3, 8'hA5};
        tbl[6]  = '{8'h5A, 3'd0, 1'b1, 2'd0, 8'h5A};
        tbl[7]  = '{8'h80, 3'd7, 1'b1, 2'd2, 8'hFF};
        tbl[8]  = '{8'h01, 3'd7, 1'b0, 2'd0, 8'h80};
        tbl[9]  = '{8'hFF, 3'd4, 1'b0, 2'd1, 8'hF0};
        tbl[10] = '{8'h81, 3'd1, 1'b0, 2'd2, 8'h02};
        tbl[11] = '{8'h7F, 3'd2, 1'b1, 2'd2, 8'h1F};
        rst = 1'b1; vld = 1'b0; rdy = 1'b1;
        data = '0; amt = '0; dir = 1'b0; op = '0;
        repeat (2) step();
        chk("rst_valid", 32'(o_valid3), 32'd0);
        chk("rst_ready", 32'(o_ready3), 32'd1);
        chk("rst_data", 32'(o_data3), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(o_ready3), 32'd1);
        chk("post_rst_valid", 32'(o_valid3), 32'd0);

        for (int i = 0; i < 12; i++) begin
            data = tbl[i].d; amt = tbl[i].a; dir = tbl[i].dr; op = tbl[i].op;
            vld = 1'b1;
            step();
            vld = 1'b0;
            n = 1;
            while (!o_valid3 && n < 8) begin
                step();
                n++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
            chk($sformatf("vec%0d_data", i), 32'(o_data3), 32'(tbl[i].exp));
            step();
        end

        vc = 0; first = -1; lastv = -1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                rand_in();
                vld = 1'b1;
                chk("b2b_ready", 32'(o_ready3), 32'd1);
            end else vld = 1'b0;
            step();
            if (o_valid3) begin
                vc++;
                if (first < 0) first = c;
                lastv = c;
            end
        end
        chk("b2b_count", 32'(vc), 32'd8);
        chk("b2b_first", 32'(first), 32'd2);
        chk("b2b_contiguous", 32'(lastv - first), 32'd7);

        rdy = 1'b0; acc = 0; held = '0;
        rand_in();
        vld = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n = int'(o_ready3);
            acc += n;
            step();
            if (c == 2) held = o_data3;
            if (n == 1) rand_in();
        end
        chk("stall_accepts", 32'(acc), 32'd3);
        chk("stall_ready_low", 32'(o_ready3), 32'd0);
        chk("stall_valid", 32'(o_valid3), 32'd1);
        chk("stall_data_held", 32'(o_data3), 32'(held));
        vld = 1'b0; rdy = 1'b1;
        repeat (6) step();
        chk("stall_drained", 32'(sbq.size()), 32'd0);
        chk("stall_idle", 32'(o_valid3), 32'd0);

        for (int c = 0; c < 3; c++) begin
            rand_in();
            vld = 1'b1;
            step();
        end
        vld = 1'b0;
        chk("pre_reset_valid", 32'(o_valid3), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(o_valid3), 32'd0);
        chk("async_reset_ready", 32'(o_ready3), 32'd1);
        chk("async_reset_data", 32'(o_data3), 32'd0);
        step();
        rst = 1'b0;
        vc = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            vc += int'(o_valid3);
        end
        chk("reset_no_stale_beats", 32'(vc), 32'd0);

        for (int c = 0; c < 300; c++) begin
            rand_in();
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            step();
        end
        vld = 1'b0; rdy = 1'b1;
        repeat (8) step();
        chk("random_drained", 32'(sbq.size()), 32'd0);

        for (int e = 1; e <= 16386; e++) begin
            if (e - 1 < 16384) begin
                {op, dir, amt, data} = 14'(e - 1);
                vld = 1'b1;
                ex[e-1] = ref_shift(data, amt, dir, op);
            end else vld = 1'b0;
            step();
            if (e - 1 < 16384) chk("exh_ns1", {23'd0, o_valid1, o_data1}, {23'd0, 1'b1, ex[e-1]});
            if (e == 1) chk("exh_ns2_latency", 32'(o_valid2), 32'd0);
            else if (e - 2 < 16384) chk("exh_ns2", {23'd0, o_valid2, o_data2}, {23'd0, 1'b1, ex[e-2]});
        end
        repeat (4) step();
        chk("final_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
